// File: rtl/soc_system_onchip_memory_master.sv
// Avalon-MM master for the single-port on-chip RAM. It runs one command at a
// time: block FILL with an incrementing pattern, block SUM (32-bit checksum),
// or block VERIFY against the same pattern. Every output is a register.
//
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while idle, so cmd_valid
// held during a command is ignored (not queued). The cmd_* fields are
// captured on the transfer edge and need not be held afterwards.
module soc_system_onchip_memory_master #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int MEM_WORDS    = 112500,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W-1:0]   cmd_len,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   result,
  output logic [ADDR_W-1:0]   first_bad_addr,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic [1:0]          state_dbg
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] OP_FILL   = 2'd0;
  localparam logic [1:0] OP_SUM    = 2'd1;
  localparam logic [1:0] OP_VERIFY = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // End-of-range limit in ADDR_W+1 bits so addr+len cannot wrap.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state, state_d;

  // Latched command
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] data_q;
  logic              load_cmd;

  // Issue bookkeeping: cnt_q = accesses issued, out_idx_q = index on the bus
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] out_idx_q, idx_d;

  // Read tracking pipe: stage 0 loads from the access currently on the bus
  logic [READ_LATENCY-1:0] rd_valid;
  logic [ADDR_W-1:0]       rd_idx [READ_LATENCY];

  // Accumulators
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mis_q, mis_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  // Sample path
  logic              sample_v;
  logic [ADDR_W-1:0] sample_idx;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;
  logic              older_pending;

  // Command checks
  logic              accept;
  logic [ADDR_W:0]   end_addr;
  logic              range_bad;

  // Next values of registered outputs
  logic              done_d, error_d, cs_d, wr_d;
  logic [DATA_W-1:0] result_d, wdata_d;
  logic [ADDR_W-1:0] fba_d, addr_d;

  assign accept    = cmd_valid && cmd_ready;
  assign end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign range_bad = (end_addr > MEM_LIMIT);
  assign state_dbg = state;

  // Sample readdata from the pipe tail and compute accumulator updates.
  always_comb begin
    sample_v      = rd_valid[READ_LATENCY-1];
    sample_idx    = rd_idx[READ_LATENCY-1];
    exp_word      = data_q + DATA_W'(sample_idx);
    mismatch      = sample_v && (op_q == OP_VERIFY) && (readdata != exp_word);
    older_pending = 1'b0;
    for (int k = 0; k < READ_LATENCY - 1; k++) begin
      older_pending = older_pending | rd_valid[k];
    end
    acc_d = acc_q;
    if (sample_v && (op_q == OP_SUM)) begin
      acc_d = acc_q + readdata;
    end
    mis_d = mis_q;
    if (mismatch) begin
      mis_d = (mis_q == {DATA_W{1'b1}}) ? mis_q : mis_q + DATA_W'(1);
    end
    found_d = found_q | mismatch;
    bad_d   = bad_q;
    if (mismatch && !found_q) begin
      bad_d = addr_q + sample_idx;
    end
  end

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    state_d  = state;
    load_cmd = 1'b0;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = address;
    wdata_d  = writedata;
    idx_d    = out_idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    error_d  = error;
    result_d = result;
    fba_d    = first_bad_addr;
    case (state)
      S_IDLE: begin
        if (accept) begin
          load_cmd = 1'b1;
          if ((cmd_op == OP_RSVD) || range_bad) begin
            state_d  = S_FINISH;
            done_d   = 1'b1;
            error_d  = 1'b1;
            result_d = '0;
            fba_d    = '0;
          end else if (cmd_len == '0) begin
            state_d  = S_FINISH;
            done_d   = 1'b1;
            error_d  = 1'b0;
            result_d = '0;
            fba_d    = '0;
          end else begin
            // Access 0 goes on the bus straight from the accepted command.
            state_d = S_ISSUE;
            cs_d    = 1'b1;
            wr_d    = (cmd_op == OP_FILL);
            addr_d  = cmd_addr;
            wdata_d = (cmd_op == OP_FILL) ? cmd_data : '0;
            idx_d   = '0;
            cnt_d   = ADDR_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == len_q) begin
          if (op_q == OP_FILL) begin
            state_d  = S_FINISH;
            done_d   = 1'b1;
            error_d  = 1'b0;
            result_d = '0;
            fba_d    = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          cs_d    = 1'b1;
          wr_d    = (op_q == OP_FILL);
          addr_d  = addr_q + cnt_q;
          wdata_d = (op_q == OP_FILL) ? data_q + DATA_W'(cnt_q) : '0;
          idx_d   = cnt_q;
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Finish on the edge that consumes the last outstanding read.
        if (!older_pending) begin
          state_d  = S_FINISH;
          done_d   = 1'b1;
          error_d  = 1'b0;
          result_d = (op_q == OP_SUM) ? acc_d : mis_d;
          fba_d    = (op_q == OP_VERIFY) ? bad_d : '0;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Registered outputs and issue bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      result         <= '0;
      first_bad_addr <= '0;
      address        <= '0;
      byteenable     <= '0;
      chipselect     <= 1'b0;
      write          <= 1'b0;
      writedata      <= '0;
      clken          <= 1'b1;
      out_idx_q      <= '0;
      cnt_q          <= '0;
    end else begin
      cmd_ready      <= (state_d == S_IDLE);
      busy           <= (state_d != S_IDLE);
      done           <= done_d;
      error          <= error_d;
      result         <= result_d;
      first_bad_addr <= fba_d;
      address        <= addr_d;
      byteenable     <= {BE_W{cs_d}};
      chipselect     <= cs_d;
      write          <= wr_d;
      writedata      <= wdata_d;
      clken          <= 1'b1;
      out_idx_q      <= idx_d;
      cnt_q          <= cnt_d;
    end
  end

  // Capture the command fields on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_FILL;
      addr_q <= '0;
      len_q  <= '0;
      data_q <= '0;
    end else if (load_cmd) begin
      op_q   <= cmd_op;
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
      data_q <= cmd_data;
    end
  end

  // Read tracking pipe: a read on the bus now is sampled READ_LATENCY edges
  // after the slave captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        rd_idx[k] <= '0;
      end
    end else begin
      rd_valid[0] <= chipselect && !write;
      rd_idx[0]   <= out_idx_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        rd_valid[k] <= rd_valid[k-1];
        rd_idx[k]   <= rd_idx[k-1];
      end
    end
  end

  // Checksum / mismatch accumulators, cleared when a command is accepted.
  always_ff @(posedge clk) begin
    if (reset || load_cmd) begin
      acc_q   <= '0;
      mis_q   <= '0;
      found_q <= 1'b0;
      bad_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mis_q   <= mis_d;
      found_q <= found_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: tb/tb_soc_system_onchip_memory_master.sv
// Bench for soc_system_onchip_memory_master: a RAM slave model with one
// cycle of read latency, a bus monitor fed by an expected-access queue, and
// one task per scenario with inline result/timing checks.
module tb_soc_system_onchip_memory_master;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 112500;
  localparam int RL        = 1;
  localparam int BE_W      = DATA_W / 8;
  localparam int SW        = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] OP_FILL   = 2'd0;
  localparam logic [1:0] OP_SUM    = 2'd1;
  localparam logic [1:0] OP_VERIFY = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] first_bad_addr;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [SW-1:0] exp_q[$];
  int            obs_cyc[$];
  logic [SW-1:0] mon_e, mon_o;

  bit [DATA_W-1:0]   mem [MEM_WORDS];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [DATA_W-1:0] poke_data = '0;

  soc_system_onchip_memory_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .error(error), .result(result),
    .first_bad_addr(first_bad_addr), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata), .clken(clken),
    .readdata(readdata), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave model: registered address, one cycle to readdata
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (chipselect && clken && (int'(address) < MEM_WORDS)) begin
      if (write) mem[address] <= writedata;
      else       readdata <= mem[address];
    end
  end

  // Bus monitor: every access must match the head of the expected queue
  always @(negedge clk) begin
    if (chipselect) begin
      checks++;
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: got addr=%0h write=%b, required no access", address, write);
      end else begin
        mon_e = exp_q.pop_front();
        mon_o = {write, address, write ? writedata : {DATA_W{1'b0}}};
        if (mon_o !== mon_e || byteenable !== {BE_W{1'b1}}) begin
          errors++;
          $display("FAIL bus_access: got we=%b addr=%0h data=%h be=%h, required we=%b addr=%0h data=%h be=%h",
                   mon_o[SW-1], mon_o[SW-2 -: ADDR_W], mon_o[DATA_W-1:0], byteenable,
                   mon_e[SW-1], mon_e[SW-2 -: ADDR_W], mon_e[DATA_W-1:0], {BE_W{1'b1}});
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] pattern_sum(input logic [DATA_W-1:0] seed, input int n);
    logic [DATA_W-1:0] s = '0;
    for (int i = 0; i < n; i++) s = s + seed + DATA_W'(i);
    return s;
  endfunction

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    poke_addr = a;
    poke_data = v;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // Driver: issue one command (called at a negedge), wait for done.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [ADDR_W-1:0] n, input logic [DATA_W-1:0] d,
                         input bit push_exp,
                         output logic [DATA_W-1:0] res, output logic [ADDR_W-1:0] fba,
                         output logic err, output int lat, output int t0);
    int k;
    bit ok;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    obs_cyc.delete();
    cmd_op = op; cmd_addr = a; cmd_len = n; cmd_data = d; cmd_valid = 1'b1;
    if (push_exp) begin
      for (int i = 0; i < int'(n); i++) begin
        wa = a + ADDR_W'(i);
        wd = (op == OP_FILL) ? d + DATA_W'(i) : '0;
        exp_q.push_back({op == OP_FILL, wa, wd});
      end
    end
    k = 0;
    while (cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    t0 = cyc;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got no done pulse, required done within 200 cycles");
    end
    lat = cyc - t0 + 1;
    res = result;
    fba = first_bad_addr;
    err = error;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bus_count: got %0d accesses missing, required 0", exp_q.size());
    end
    exp_q.delete();
    if (push_exp && n != 0) begin
      checks++;
      ok = (obs_cyc.size() == int'(n));
      if (ok) for (int i = 0; i < int'(n); i++) if (obs_cyc[i] != t0 + i) ok = 0;
      if (!ok) begin
        errors++;
        $display("FAIL bus_timing: got %0d accesses first at cycle %0d, required %0d consecutive from %0d",
                 obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, n, t0);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready, busy, done, error, chipselect, write, clken, byteenable} !== {7'b1000001, {BE_W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/done/err/cs/wr/clken/be=%b%b%b%b%b%b%b/%h, required 1000001/0",
               cmd_ready, busy, done, error, chipselect, write, clken, byteenable);
    end
    checks++;
    if (result !== '0 || first_bad_addr !== '0 || address !== '0 || writedata !== '0) begin
      errors++;
      $display("FAIL reset_values: got result=%h fba=%h addr=%h wdata=%h, required all 0",
               result, first_bad_addr, address, writedata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || clken !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b clken=%b, required 1 0 1", cmd_ready, busy, clken);
    end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    run_cmd(OP_FILL, 17'h10, 17'd4, 32'hFFFF_FFFE, 1, res, fba, err, lat, t0);
    checks++;
    if (lat != 5 || err !== 1'b0 || res !== '0) begin
      errors++;
      $display("FAIL fill_done: got lat=%0d err=%b result=%h, required 5 0 0", lat, err, res);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_pulse: got done=%b rdy=%b busy=%b, required 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_sum();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    logic [DATA_W-1:0] want;
    want = pattern_sum(32'hFFFF_FFFE, 4);
    run_cmd(OP_SUM, 17'h10, 17'd4, 32'h0, 1, res, fba, err, lat, t0);
    checks++;
    if (res !== want || lat != 4 + RL + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL sum_basic: got result=%h lat=%0d err=%b, required %h %0d 0", res, lat, err, want, 4 + RL + 1);
    end
    @(negedge clk);
    checks++;
    if (result !== want) begin
      errors++;
      $display("FAIL sum_hold: got result=%h, required %h", result, want);
    end
  endtask

  task automatic test_verify();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    run_cmd(OP_VERIFY, 17'h10, 17'd4, 32'hFFFF_FFFE, 1, res, fba, err, lat, t0);
    checks++;
    if (res !== 32'd0 || fba !== '0 || lat != 4 + RL + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL verify_clean: got result=%0d fba=%h lat=%0d err=%b, required 0 0 %0d 0", res, fba, lat, err, 4 + RL + 1);
    end
    poke(17'h12, 32'hFFFF_FFFF);
    poke(17'h13, 32'h1234_5678);
    run_cmd(OP_VERIFY, 17'h10, 17'd4, 32'hFFFF_FFFE, 1, res, fba, err, lat, t0);
    checks++;
    if (res !== 32'd2 || fba !== 17'h12 || err !== 1'b0) begin
      errors++;
      $display("FAIL verify_bad: got result=%0d fba=%h err=%b, required 2 12 0", res, fba, err);
    end
  endtask

  task automatic test_reject();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    run_cmd(OP_SUM, 17'd112499, 17'd2, 32'h0, 0, res, fba, err, lat, t0);
    checks++;
    if (lat != 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL reject_range: got lat=%0d err=%b, required 1 1", lat, err);
    end
    run_cmd(OP_RSVD, 17'h20, 17'd4, 32'h0, 0, res, fba, err, lat, t0);
    checks++;
    if (lat != 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL reject_op3: got lat=%0d err=%b, required 1 1", lat, err);
    end
  endtask

  task automatic test_zero_len();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    run_cmd(OP_VERIFY, 17'h5, 17'd0, 32'h0, 0, res, fba, err, lat, t0);
    checks++;
    if (lat != 1 || err !== 1'b0 || res !== '0) begin
      errors++;
      $display("FAIL zero_len: got lat=%0d err=%b result=%h, required 1 0 0", lat, err, res);
    end
  endtask

  task automatic test_edge();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    logic [DATA_W-1:0] seed;
    seed = $urandom;
    run_cmd(OP_FILL, 17'd112499, 17'd1, seed, 1, res, fba, err, lat, t0);
    checks++;
    if (lat != 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL edge_fill: got lat=%0d err=%b, required 2 0", lat, err);
    end
    run_cmd(OP_SUM, 17'd112499, 17'd1, 32'h0, 1, res, fba, err, lat, t0);
    checks++;
    if (res !== seed || lat != 1 + RL + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL edge_sum: got result=%h lat=%0d err=%b, required %h %0d 0", res, lat, err, seed, 1 + RL + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0, t0b, lat_b;
    logic [DATA_W-1:0] seed;
    seed = $urandom;
    run_cmd(OP_FILL, 17'h100, 17'd3, seed, 1, res, fba, err, lat, t0);
    run_cmd(OP_VERIFY, 17'h100, 17'd3, seed, 1, res, fba, err, lat_b, t0b);
    checks++;
    if (t0b != t0 + lat - 1 + 2 || res !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: got handshake at %0d result=%0d err=%b, required %0d 0 0",
               t0b, res, err, t0 + lat + 1);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    logic [DATA_W-1:0] seed, want;
    logic [ADDR_W-1:0] a, n;
    for (int it = 0; it < 3; it++) begin
      seed = $urandom;
      a    = ADDR_W'($urandom_range(256, 2000));
      n    = ADDR_W'($urandom_range(1, 12));
      want = pattern_sum(seed, int'(n));
      run_cmd(OP_FILL, a, n, seed, 1, res, fba, err, lat, t0);
      run_cmd(OP_SUM, a, n, 32'h0, 1, res, fba, err, lat, t0);
      checks++;
      if (res !== want || lat != int'(n) + RL + 1) begin
        errors++;
        $display("FAIL random_sum: got result=%h lat=%0d, required %h %0d", res, lat, want, int'(n) + RL + 1);
      end
      run_cmd(OP_VERIFY, a, n, seed, 1, res, fba, err, lat, t0);
      checks++;
      if (res !== '0 || fba !== '0) begin
        errors++;
        $display("FAIL random_verify: got result=%0d fba=%h, required 0 0", res, fba);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] res; logic [ADDR_W-1:0] fba; logic err; int lat, t0;
    logic [DATA_W-1:0] init [8];
    logic [DATA_W-1:0] seed, want;
    bit saw_done;
    seed = $urandom;
    for (int i = 0; i < 8; i++) begin
      init[i] = $urandom;
      poke(ADDR_W'(17'h40 + i), init[i]);
    end
    exp_q.push_back({1'b1, 17'h40, seed});
    exp_q.push_back({1'b1, 17'h41, seed + 32'd1});
    cmd_op = OP_FILL; cmd_addr = 17'h40; cmd_len = 17'd8; cmd_data = seed; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (chipselect !== 1'b0 || write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bus: got cs=%b wr=%b done=%b, required 0 0 0", chipselect, write, done);
    end
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got done_seen=%b rdy=%b busy=%b, required 0 1 0", saw_done, cmd_ready, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_access: got %0d writes missing, required 0", exp_q.size());
    end
    exp_q.delete();
    want = seed + (seed + 32'd1);
    for (int i = 2; i < 8; i++) want = want + init[i];
    run_cmd(OP_SUM, 17'h40, 17'd8, 32'h0, 1, res, fba, err, lat, t0);
    checks++;
    if (res !== want || lat != 8 + RL + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sum: got result=%h lat=%0d err=%b, required %h %0d 0", res, lat, err, want, 8 + RL + 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_fill();
    test_sum();
    test_verify();
    test_reject();
    test_zero_len();
    test_edge();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_onchip_memory_master.md
Name: soc_system_onchip_memory_master

Overview:
- Avalon-MM master that drives the single-port 32-bit on-chip RAM slave: address, byteenable, chipselect, write, writedata, clken in; readdata out.
- Executes one command at a time from a simple valid/ready command port:
  - block fill with an incrementing pattern,
  - block read with a 32-bit checksum,
  - block verify against the same pattern.
- Used by the HPS-side control logic and by system test to initialise and check the shared memory region.

Parameters:
- ADDR_W, 17, word-address width of the slave.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MEM_WORDS, 112500, number of valid words; the legal range is 0..MEM_WORDS-1.
- READ_LATENCY, 1, cycles from the address cycle to valid readdata. The slave output is unregistered, so this is 1. Legal values are 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_op  in  2  operation: 0 = FILL, 1 = SUM, 2 = VERIFY, 3 = reserved (rejected).
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  ADDR_W  word count.
- cmd_data  in  DATA_W  pattern seed.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; the command was rejected.
- result  out  DATA_W  valid with done: checksum (SUM) or mismatch count (VERIFY); 0 for FILL.
- first_bad_addr  out  ADDR_W  valid with done for VERIFY: address of the first mismatch; 0 if there is none.
- address  out  ADDR_W  slave word address.
- byteenable  out  DATA_W/8  always all-ones while chipselect is high.
- chipselect  out  1  slave access strobe.
- write  out  1  write strobe.
- writedata  out  DATA_W  write data.
- clken  out  1  slave clock enable; held at 1 out of reset.
- readdata  in  DATA_W  slave read data.

Behaviour:
- Reset:
  - Every output is registered.
  - After reset: cmd_ready=1, busy=0, done=0, error=0, result=0, first_bad_addr=0, chipselect=0, write=0, address=0, writedata=0, byteenable=0, clken=1.
  - Reset mid-command: the command is abandoned; on the next edge chipselect/write=0 and no done pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) at edge T latches all cmd_* fields and drops cmd_ready.
  - Rejection cases go straight to FINISH with error=1 and no slave access:
    - cmd_op=3;
    - cmd_addr+cmd_len > MEM_WORDS, computed with ADDR_W+1 bits, so there is no wrap-around.
  - cmd_len=0 goes to FINISH with error=0, result=0 and no access.
  - Otherwise go to ISSUE.
- ISSUE:
  - One access per cycle, no gaps; the slave has no waitrequest.
  - Access i (i = 0..len-1) is presented at cycle T+1+i with address = cmd_addr+i and chipselect=1.
  - FILL: write=1 and writedata = cmd_data+i, modulo 2^DATA_W.
  - SUM/VERIFY: write=0.
  - After the last access:
    - FILL goes to FINISH;
    - SUM/VERIFY go to DRAIN.
- Read tracking:
  - A READ_LATENCY-deep shift register of valid bits and indices.
  - readdata is sampled exactly READ_LATENCY cycles after its address cycle.
  - SUM: acc += readdata, modulo 2^DATA_W.
  - VERIFY: a mismatch is readdata != cmd_data+i. Each mismatch increments a saturating counter. The first mismatch records cmd_addr+i; later mismatches do not overwrite it.
- DRAIN:
  - Waits until the shift register is empty.
  - The last sample lands at T+len+READ_LATENCY.
- FINISH:
  - Lasts exactly one cycle: done=1 and result/first_bad_addr/error are valid. These outputs hold until the next command is accepted.
  - Returns to IDLE with cmd_ready=1 on the following cycle.
- Done timing:
  - FILL: done at T+len+1.
  - SUM/VERIFY: done at T+len+READ_LATENCY+1.
  - Rejected or zero-length commands: done at T+1.
- busy = !cmd_ready, excluding the reset state.
- chipselect is never high outside ISSUE.
- cmd_valid asserted while busy is ignored; it is not queued.
- Back-to-back commands: a new handshake is possible on the cycle after done.
- Boundary case: cmd_addr=MEM_WORDS-1 with cmd_len=1 is legal.

Test Plan:
- FILL at addr=0x10, len=4, data=0xFFFFFFFE → writes to 0x10..0x13 with data FFFFFFFE, FFFFFFFF, 00000000, 00000001 on consecutive cycles; done at T+5, error=0.
- Then SUM at addr=0x10, len=4 → result=0xFFFFFFFE (sum modulo 2^32); done at T+6 with READ_LATENCY=1.
- VERIFY at addr=0x10, len=4, data=0xFFFFFFFE after the bench corrupts word 0x12 and then 0x13 → result=2, first_bad_addr=0x12.
- Rejected commands → done at T+1, error=1, no chipselect:
  - addr=112499, len=2;
  - cmd_op=3.
- Zero-length command: cmd_len=0 → done at T+1, error=0, result=0.
- Edge-of-memory command: addr=112499, len=1 → legal, single access.
- Reset asserted two cycles into a len=8 FILL → chipselect=0 on the next edge; no done pulse; cmd_ready=1 after reset releases; a new SUM command then completes normally.
